// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token constants, receiver FSM states
// and the token matcher shared by the receive path.
package tmds_pkg;

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL10 = 10'b0101010100;
  localparam logic [9:0] CTL11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic tmds_is_token(
    input logic [9:0] q
  );
    return (q == CTL00) || (q == CTL01) ||
           (q == CTL10) || (q == CTL11);
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational TMDS symbol decoder.
// Ports: i_sym (10-bit symbol) -> o_de, o_ctrl {C1,C0}, o_data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_de,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_data
);

  logic [7:0] w_d;

  // q[9] flags a transmit-side inversion of the low byte
  assign w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

  always_comb begin
    o_de   = 1'b1;
    o_ctrl = 2'b00;
    o_data = 8'h00;
    unique case (i_sym)
      CTL00: o_de = 1'b0;
      CTL01: begin
        o_de   = 1'b0;
        o_ctrl = 2'b01;
      end
      CTL10: begin
        o_de   = 1'b0;
        o_ctrl = 2'b10;
      end
      CTL11: begin
        o_de   = 1'b0;
        o_ctrl = 2'b11;
      end
      default: begin
        // q[8] selects XOR (1) or XNOR (0) chaining
        o_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
          o_data[i] = i_sym[8] ?
            (w_d[i] ^ w_d[i-1]) :
            ~(w_d[i] ^ w_d[i-1]);
        end
      end
    endcase
  end

endmodule

// File: rtl/tmds_channel_receiver.sv
// tmds_channel_receiver: aligns raw deserializer words on TMDS tokens.
// Ports: clk_pixel, reset_n, raw_word, relock -> locked, offset, symbol, de, ctrl, data.
module tmds_channel_receiver
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS     = 12,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] raw_word,
  input  logic       relock,
  output logic       locked,
  output logic [3:0] offset,
  output logic [9:0] symbol,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_TOKENS);
  localparam logic [WW-1:0] WD_MAX = WW'(WATCHDOG_CYCLES);

  state_e        r_state;
  logic [9:0]    r_cur;
  logic [9:0]    r_prev;
  logic [3:0]    r_offset;
  logic [RW-1:0] r_run;
  logic [WW-1:0] r_wd;
  logic [9:0]    r_symbol;
  logic          r_de;
  logic [1:0]    r_ctrl;
  logic [7:0]    r_data;

  logic [18:0]   w_hist;
  logic [9:0]    w_win [10];
  logic [9:0]    w_match;
  logic          w_any;
  logic [3:0]    w_first;
  logic [9:0]    w_sel;
  logic          w_tok;
  logic [RW-1:0] w_run_inc;
  logic [WW-1:0] w_wd_inc;
  logic          w_complete;
  logic          w_expire;
  logic          w_stay;
  logic          w_de;
  logic [1:0]    w_ctrl;
  logic [7:0]    w_data;

  // bit 0 of w_hist is the oldest received bit
  assign w_hist = {r_cur[8:0], r_prev};

  for (genvar k = 0; k < 10; k++) begin : g_match
    assign w_win[k]   = w_hist[k+9:k];
    assign w_match[k] = tmds_is_token(w_win[k]);
  end

  assign w_any = |w_match;

  always_comb begin
    w_first = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (w_match[k]) w_first = 4'(k);
    end
  end

  always_comb begin
    w_sel = w_win[0];
    for (int k = 1; k < 10; k++) begin
      if (r_offset == 4'(k)) w_sel = w_win[k];
    end
  end

  assign w_tok      = tmds_is_token(w_sel);
  assign w_run_inc  = r_run + RW'(1);
  assign w_wd_inc   = r_wd + WW'(1);
  assign w_complete = w_tok && (r_run != RUN_MAX) &&
                      (w_run_inc == RUN_MAX);
  assign w_expire   = (w_wd_inc == WD_MAX);

  // decode only while locked both before and after this edge
  assign w_stay = (r_state == LOCKED) && !relock &&
                  (w_complete || !w_expire);

  tmds_symbol_decode u_dec (
    .i_sym  (w_sel),
    .o_de   (w_de),
    .o_ctrl (w_ctrl),
    .o_data (w_data)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= SEARCH;
      r_cur    <= '0;
      r_prev   <= '0;
      r_offset <= '0;
      r_run    <= '0;
      r_wd     <= '0;
      r_symbol <= '0;
      r_de     <= 1'b0;
      r_ctrl   <= '0;
      r_data   <= '0;
    end else begin
      r_cur  <= raw_word;
      r_prev <= r_cur;

      if (w_stay) begin
        r_symbol <= w_sel;
        r_de     <= w_de;
        r_ctrl   <= w_ctrl;
        r_data   <= w_data;
      end else begin
        r_symbol <= '0;
        r_de     <= 1'b0;
        r_ctrl   <= '0;
        r_data   <= '0;
      end

      if (relock) begin
        r_state <= SEARCH;
        r_run   <= '0;
        r_wd    <= '0;
      end else begin
        case (r_state)
          SEARCH: begin
            if (w_any) begin
              r_offset <= w_first;
              r_run    <= RW'(1);
              r_state  <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_tok) begin
              r_run <= w_run_inc;
              if (w_run_inc == RUN_MAX) begin
                r_state <= LOCKED;
                r_wd    <= '0;
              end
            end else begin
              r_state <= SEARCH;
              r_run   <= '0;
            end
          end
          LOCKED: begin
            if (!w_tok) r_run <= '0;
            else if (r_run != RUN_MAX) r_run <= w_run_inc;
            // a completed run beats a same-cycle expiry
            if (w_complete) begin
              r_wd <= '0;
            end else if (w_expire) begin
              r_state <= SEARCH;
              r_wd    <= '0;
              r_run   <= '0;
            end else begin
              r_wd <= w_wd_inc;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign locked = (r_state == LOCKED);
  assign offset = r_offset;
  assign symbol = r_symbol;
  assign de     = r_de;
  assign ctrl   = r_ctrl;
  assign data   = r_data;

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// tb_tmds_channel_receiver: randomized and directed checks of the
// TMDS channel receiver against a bench-side reference model.
module tb_tmds_channel_receiver;

  localparam int LT  = 12;
  localparam int WDC = 4096;
  localparam logic [9:0] TOK [4] = '{
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011
  };

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b0;
  logic [9:0] raw_word  = '0;
  logic       relock    = 1'b0;
  logic       locked;
  logic [3:0] offset;
  logic [9:0] symbol;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;

  int total = 0;
  int bad   = 0;

  int m_hist, m_st, m_off, m_run, m_wd;
  logic [9:0]  m_sym;
  logic [10:0] m_dec;
  bit bq[$];

  tmds_channel_receiver #(
    .LOCK_TOKENS     (LT),
    .WATCHDOG_CYCLES (WDC)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .raw_word  (raw_word),
    .relock    (relock),
    .locked    (locked),
    .offset    (offset),
    .symbol    (symbol),
    .de        (de),
    .ctrl      (ctrl),
    .data      (data)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic int tok_idx(input logic [9:0] q);
    for (int i = 0; i < 4; i++) if (q == TOK[i]) return i;
    return -1;
  endfunction

  function automatic logic [10:0] ref_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    int ix;
    ix = tok_idx(q);
    if (ix >= 0) return {1'b0, 2'(ix), 8'h00};
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~q[8];
    return {1'b1, 2'b00, o};
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (tok_idx(w) >= 0);
    return w;
  endfunction

  task automatic mreset();
    m_hist = 0; m_st = 0; m_off = 0; m_run = 0; m_wd = 0;
    m_sym = '0; m_dec = '0;
  endtask

  task automatic model_step(input logic [9:0] w, input logic rl);
    logic [9:0] a;
    int first, ns, nrun;
    bit t, done;
    a = 10'((m_hist >> m_off) & 32'h3FF);
    t = (tok_idx(a) >= 0);
    first = -1;
    for (int k = 9; k >= 0; k--)
      if (tok_idx(10'((m_hist >> k) & 32'h3FF)) >= 0) first = k;
    ns = m_st;
    done = 0;
    if (rl) begin
      ns = 0; m_run = 0; m_wd = 0;
    end else if (m_st == 0) begin
      if (first >= 0) begin m_off = first; m_run = 1; ns = 1; end
    end else if (m_st == 1) begin
      if (t) begin
        m_run++;
        if (m_run == LT) begin ns = 2; m_wd = 0; end
      end else begin
        ns = 0; m_run = 0;
      end
    end else begin
      nrun = t ? ((m_run < LT) ? m_run + 1 : LT) : 0;
      done = t && (m_run < LT) && (nrun == LT);
      m_run = nrun;
      if (done) m_wd = 0;
      else if (m_wd + 1 == WDC) begin ns = 0; m_wd = 0; m_run = 0; end
      else m_wd++;
    end
    if (m_st == 2 && ns == 2) begin
      m_sym = a; m_dec = ref_decode(a);
    end else begin
      m_sym = '0; m_dec = '0;
    end
    m_st = ns;
    m_hist = (int'(w) << 10) | ((m_hist >> 10) & 32'h3FF);
  endtask

  task automatic cyc(input logic [9:0] w, input logic rl);
    raw_word = w;
    relock   = rl;
    @(posedge clk_pixel);
    model_step(w, rl);
    @(negedge clk_pixel);
    relock = 1'b0;
  endtask

  task automatic push_sym(input logic [9:0] q);
    for (int i = 0; i < 10; i++) bq.push_back(q[i]);
  endtask

  task automatic pop_word(output logic [9:0] w);
    for (int i = 0; i < 10; i++) w[i] = (bq.size() > 0) ? bq.pop_front() : 1'b0;
  endtask

  task automatic drain();
    logic [9:0] w;
    while (bq.size() >= 10) begin
      pop_word(w);
      cyc(w, 1'b0);
    end
  endtask

  task automatic restart();
    cyc(10'h000, 1'b1);
    repeat (3) cyc(10'h000, 1'b0);
    bq.delete();
  endtask

  task automatic test_reset();
    mreset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_pixel);
    if ({locked, offset, symbol, de, ctrl, data} !== 26'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0",
               {locked, offset, symbol, de, ctrl, data});
    end
    total++;
    reset_n = 1'b1;
    repeat (4) cyc(10'h000, 1'b0);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL reset_idle locked=%b exp=0", locked);
    end
    total++;
  endtask

  task automatic test_lock_offset0();
    restart();
    repeat (13) cyc(TOK[0], 1'b0);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL lock0_early locked=%b exp=0", locked);
    end
    total++;
    cyc(TOK[0], 1'b0);
    if (locked !== 1'b1 || offset !== 4'd0) begin
      bad++; $display("FAIL lock0_rise locked=%b offset=%0d exp=1/0", locked, offset);
    end
    total++;
    if (symbol !== 10'h000) begin
      bad++; $display("FAIL lock0_first_sym symbol=%h exp=000", symbol);
    end
    total++;
    cyc(TOK[0], 1'b0);
    if (de !== 1'b0 || ctrl !== 2'b00 || symbol !== TOK[0]) begin
      bad++;
      $display("FAIL lock0_ctrl de=%b ctrl=%b sym=%h exp=0/00/%h", de, ctrl, symbol, TOK[0]);
    end
    total++;
  endtask

  task automatic test_data_decode();
    restart();
    repeat (15) cyc(TOK[0], 1'b0);
    cyc(10'b0111111111, 1'b0);
    cyc(10'b1000000000, 1'b0);
    if (de !== 1'b0) begin
      bad++; $display("FAIL data_latency de=%b exp=0", de);
    end
    total++;
    cyc(TOK[0], 1'b0);
    if (de !== 1'b1 || data !== 8'h01 || symbol !== 10'h1FF) begin
      bad++; $display("FAIL data_01 de=%b data=%h sym=%h exp=1/01/1ff", de, data, symbol);
    end
    total++;
    cyc(TOK[0], 1'b0);
    if (de !== 1'b1 || data !== 8'hFF || ctrl !== 2'b00) begin
      bad++; $display("FAIL data_ff de=%b data=%h ctrl=%b exp=1/ff/00", de, data, ctrl);
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL data_keep_lock locked=%b exp=1", locked);
    end
    total++;
  endtask

  task automatic test_phase3();
    restart();
    repeat (3) bq.push_back(1'b0);
    repeat (16) push_sym(TOK[3]);
    drain();
    bq.delete();
    if (locked !== 1'b1 || offset !== 4'd3) begin
      bad++; $display("FAIL phase3_lock locked=%b offset=%0d exp=1/3", locked, offset);
    end
    total++;
    if (de !== 1'b0 || ctrl !== 2'b11) begin
      bad++; $display("FAIL phase3_ctrl de=%b ctrl=%b exp=0/11", de, ctrl);
    end
    total++;
  endtask

  task automatic test_token_break();
    restart();
    repeat (11) cyc(TOK[1], 1'b0);
    cyc(rand_data(), 1'b0);
    repeat (13) cyc(TOK[1], 1'b0);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL break_no_lock locked=%b exp=0", locked);
    end
    total++;
    cyc(TOK[1], 1'b0);
    if (locked !== 1'b1) begin
      bad++; $display("FAIL break_relock locked=%b exp=1", locked);
    end
    total++;
  endtask

  task automatic test_relock_locked();
    restart();
    repeat (16) cyc(TOK[2], 1'b0);
    if (locked !== 1'b1 || ctrl !== 2'b10) begin
      bad++; $display("FAIL relock_pre locked=%b ctrl=%b exp=1/10", locked, ctrl);
    end
    total++;
    cyc(TOK[2], 1'b1);
    if ({locked, symbol, de, ctrl, data} !== 22'h0) begin
      bad++;
      $display("FAIL relock_clear got=%h exp=0", {locked, symbol, de, ctrl, data});
    end
    total++;
  endtask

  task automatic test_relock_on_complete();
    restart();
    repeat (13) cyc(TOK[0], 1'b0);
    cyc(TOK[0], 1'b1);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL relock_complete locked=%b exp=0", locked);
    end
    total++;
    cyc(TOK[0], 1'b0);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL relock_complete_next locked=%b exp=0", locked);
    end
    total++;
  endtask

  task automatic test_mid_verify_reset();
    restart();
    repeat (3) bq.push_back(1'b0);
    repeat (6) push_sym(TOK[0]);
    drain();
    bq.delete();
    if (locked !== 1'b0 || offset !== 4'd3) begin
      bad++; $display("FAIL verify_pre locked=%b offset=%0d exp=0/3", locked, offset);
    end
    total++;
    #2 reset_n = 1'b0;
    mreset();
    #1;
    if ({locked, offset, symbol, de, ctrl, data} !== 26'h0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {locked, offset, symbol, de, ctrl, data});
    end
    total++;
    @(negedge clk_pixel);
    reset_n = 1'b1;
  endtask

  task automatic test_watchdog_expire();
    restart();
    repeat (14) cyc(TOK[0], 1'b0);
    repeat (WDC - 1) cyc(rand_data(), 1'b0);
    if (locked !== 1'b1) begin
      bad++; $display("FAIL wd_before locked=%b exp=1", locked);
    end
    total++;
    cyc(rand_data(), 1'b0);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL wd_expire locked=%b exp=0", locked);
    end
    total++;
  endtask

  task automatic test_watchdog_rearm();
    int c;
    restart();
    repeat (14) cyc(TOK[0], 1'b0);
    c = 0;
    repeat (3999) begin cyc(rand_data(), 1'b0); c++; end
    repeat (12) begin cyc(TOK[0], 1'b0); c++; end
    while (c < 4108) begin cyc(rand_data(), 1'b0); c++; end
    if (locked !== 1'b1) begin
      bad++; $display("FAIL wd_rearm_hold locked=%b exp=1", locked);
    end
    total++;
    while (c < 8108) begin cyc(rand_data(), 1'b0); c++; end
    if (locked !== 1'b1) begin
      bad++; $display("FAIL wd_rearm_last locked=%b exp=1", locked);
    end
    total++;
    cyc(rand_data(), 1'b0);
    if (locked !== 1'b0) begin
      bad++; $display("FAIL wd_rearm_expire locked=%b exp=0", locked);
    end
    total++;
  endtask

  task automatic test_random();
    logic [9:0] w;
    logic [25:0] got, exp;
    for (int b = 0; b < 300; b++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        logic [9:0] t;
        t = TOK[$urandom_range(0, 3)];
        repeat ($urandom_range(4, 18)) push_sym(t);
      end else if (kind < 8) begin
        repeat ($urandom_range(1, 5)) push_sym(10'($urandom_range(0, 1023)));
      end else begin
        repeat ($urandom_range(1, 9)) bq.push_back(1'($urandom_range(0, 1)));
      end
      while (bq.size() >= 10) begin
        pop_word(w);
        cyc(w, ($urandom_range(0, 199) == 0));
        got = {locked, offset, symbol, de, ctrl, data};
        exp = {(m_st == 2), 4'(m_off), m_sym, m_dec};
        if (got !== exp) begin
          bad++; $display("FAIL random_cycle got=%h exp=%h", got, exp);
        end
        total++;
      end
    end
    bq.delete();
  endtask

  initial begin
    test_reset();
    test_lock_offset0();
    test_data_decode();
    test_phase3();
    test_token_break();
    test_relock_locked();
    test_relock_on_complete();
    test_mid_verify_reset();
    test_watchdog_expire();
    test_watchdog_rearm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
